// File: rtl/mmu_paged.sv
// Paging MMU for the 6809 SBC: per-task page table, write-protect fault capture, init walker.
// Optional MMU_VECTOR_TASK_EN: hardware task switch to task 0 on interrupt-vector fetch.
module mmu_paged #(
    parameter logic [15:0] IO_PAGE   = 16'hFE00,
    parameter int          PAGE_BITS = 3,
    parameter int          TASK_BITS = 5,
    parameter int          PPN_BITS  = 7
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                CPU_EN,
    input  logic [15:0]         ADDR,
    input  logic                RnW,
    input  logic                BA,
    input  logic                BS,
    input  logic [7:0]          DIN,
    output logic [7:0]          DOUT,
    output logic                DOE,
    output logic [PPN_BITS-1:0] PPN,
    output logic                WR_INH,
    output logic                BUSY,
    output logic                IRQ_FAULT
);

    localparam int IDX_BITS = TASK_BITS + PAGE_BITS;
    localparam int ENTRIES  = 1 << IDX_BITS;
    localparam logic [7:0] WIN_MASK = 8'((1 << PAGE_BITS) - 1);
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_IDLE = 1'b1;

    logic [0:0]          state;
    logic [IDX_BITS-1:0] init_cnt;
    logic                en_mmu, wp_en, firq_en;
    logic [TASK_BITS-1:0] access_key, task_key, prev_task, fault_task;
    logic                fault;
    logic [15:0]         faddr;

    // Each entry keeps only WP (top bit) and the PPN; other bits read back as 0.
    logic [PPN_BITS:0]   table_q [ENTRIES];

    logic                io_sel, win_sel, reg_sel, wr_reg, ctrl_wr, fstat_clr;
    logic [7:0]          off;
    logic [IDX_BITS-1:0] win_idx, xl_idx, tbl_wa;
    logic [PPN_BITS:0]   win_entry, xl_entry, tbl_wd;
    logic                tbl_we;

    assign off       = ADDR[7:0];
    assign io_sel    = (ADDR[15:8] == IO_PAGE[15:8]);
    assign win_sel   = io_sel && ((off & ~WIN_MASK) == 8'h20);
    assign reg_sel   = (io_sel && off >= 8'h10 && off <= 8'h16) || win_sel;
    assign wr_reg    = CPU_EN && !RnW && io_sel;
    assign ctrl_wr   = wr_reg && (off == 8'h10);
    assign fstat_clr = wr_reg && (off == 8'h14) && DIN[7];

    assign win_idx   = {access_key, off[PAGE_BITS-1:0]};
    assign xl_idx    = {task_key, ADDR[15:16-PAGE_BITS]};
    assign win_entry = table_q[win_idx];
    assign xl_entry  = table_q[xl_idx];

    assign BUSY      = (state == ST_INIT);
    assign PPN       = (en_mmu && !BUSY) ? xl_entry[PPN_BITS-1:0]
                                         : PPN_BITS'(ADDR[15:16-PAGE_BITS]);
    assign WR_INH    = en_mmu && wp_en && !BUSY && xl_entry[PPN_BITS] && !RnW && !io_sel;
    assign IRQ_FAULT = fault && firq_en;
    assign DOE       = RnW && reg_sel;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        DOUT = '0;
        if (io_sel) begin
            case (off)
                8'h10: DOUT = {BUSY, 4'b0000, firq_en, wp_en, en_mmu};
                8'h11: DOUT = 8'(access_key);
                8'h12: DOUT = 8'(task_key);
                8'h13: DOUT = 8'(prev_task);
                8'h14: DOUT = {fault, 2'b00, 5'(fault_task)};
                8'h15: DOUT = faddr[15:8];
                8'h16: DOUT = faddr[7:0];
                default: begin
                    if (win_sel) begin
                        DOUT    = 8'(win_entry[PPN_BITS-1:0]);
                        DOUT[7] = win_entry[PPN_BITS];
                    end
                end
            endcase
        end
    end

    // The init walk owns the table write port while BUSY, so CPU window writes are dropped then.
    always_comb begin
        tbl_we = 1'b0;
        tbl_wa = init_cnt;
        tbl_wd = {1'b0, PPN_BITS'(init_cnt[PAGE_BITS-1:0])};
        if (BUSY) begin
            tbl_we = 1'b1;
        end else if (wr_reg && win_sel) begin
            tbl_we = 1'b1;
            tbl_wa = win_idx;
            tbl_wd = {DIN[7], DIN[PPN_BITS-1:0]};
        end
    end

    // NOTE: the table has no reset; the init walk gives it defined contents instead.
    always_ff @(posedge CLK) begin
        if (tbl_we) table_q[tbl_wa] <= tbl_wd;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else if (BUSY) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == '1) state <= ST_IDLE;
        end else if (ctrl_wr && DIN[7]) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            en_mmu     <= 1'b0;
            wp_en      <= 1'b0;
            firq_en    <= 1'b0;
            access_key <= '0;
            task_key   <= '0;
            fault      <= 1'b0;
            fault_task <= '0;
            faddr      <= '0;
        end else begin
            if (ctrl_wr) {firq_en, wp_en, en_mmu} <= DIN[2:0];
            if (wr_reg && off == 8'h11) access_key <= DIN[TASK_BITS-1:0];
            if (wr_reg && off == 8'h12) task_key <= DIN[TASK_BITS-1:0];
            // A clear arriving with a new fault lets the new fault re-arm FAULT.
            if (CPU_EN && WR_INH && (!fault || fstat_clr)) begin
                fault      <= 1'b1;
                faddr      <= ADDR;
                fault_task <= task_key;
            end else if (fstat_clr) begin
                fault <= 1'b0;
            end
`ifdef MMU_VECTOR_TASK_EN
            if (wr_reg && off == 8'h13) task_key <= prev_task;
            if (CPU_EN && BS && !BA && en_mmu) task_key <= '0;
`endif
        end
    end

`ifdef MMU_VECTOR_TASK_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prev_task <= '0;
        end else if (CPU_EN && BS && !BA && en_mmu && task_key != '0) begin
            prev_task <= task_key;
        end
    end
`else
    logic unused_vec_status;
    assign prev_task         = '0;
    assign unused_vec_status = BA ^ BS;
`endif

endmodule
